// File: rtl/output_router_pkg.sv
// Shared types and sizing helpers for the requantizing output router.
package output_router_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OUT  = 1'b1
    } state_t;

    // Elements of width dw that fit (rounded up) into one SPAD word of width sdw.
    function automatic int calc_member_cnt(input int sdw, input int dw);
        return (sdw + dw - 1) / dw;
    endfunction

    // SPAD words needed to hold rc lanes at mc lanes per word.
    function automatic int calc_group_cnt(input int rc, input int mc);
        return (rc + mc - 1) / mc;
    endfunction

    // Largest value representable in a signed dw-bit element.
    function automatic int sat_max(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    // Smallest value representable in a signed dw-bit element.
    function automatic int sat_min(input int dw);
        return -(1 << (dw - 1));
    endfunction

endpackage

// File: rtl/requant_unit.sv
// One lane of requantization: optional ReLU, round-half-up right shift,
// then signed saturation to DATA_WIDTH. Purely combinational.
module requant_unit
    import output_router_pkg::*;
#(
    parameter int ACC_WIDTH   = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int SHIFT_WIDTH = 4
) (
    input  logic signed [ACC_WIDTH-1:0]   x,
    input  logic                          valid,
    input  logic                          relu_en,
    input  logic        [SHIFT_WIDTH-1:0] shift,
    output logic        [DATA_WIDTH-1:0]  y
);

    // One extra bit so adding the rounding constant can never overflow.
    localparam int EXT_W = ACC_WIDTH + 1;

    logic signed [EXT_W-1:0] x_ext;
    logic signed [EXT_W-1:0] rnd;
    logic signed [EXT_W-1:0] sum;
    logic signed [EXT_W-1:0] shifted;
    int                      shifted_int;

    // Round, shift and clamp the lane value.
    always_comb begin
        x_ext = {x[ACC_WIDTH-1], x};
        rnd   = '0;
        if (shift != '0) begin
            rnd = EXT_W'(1) << (shift - SHIFT_WIDTH'(1));
        end
        sum         = x_ext + rnd;
        shifted     = sum >>> shift;
        shifted_int = int'(shifted);

        y = '0;
        if (!valid || (relu_en && x[ACC_WIDTH-1])) begin
            y = '0;
        end else if (shifted_int > sat_max(DATA_WIDTH)) begin
            y = DATA_WIDTH'(sat_max(DATA_WIDTH));
        end else if (shifted_int < sat_min(DATA_WIDTH)) begin
            y = DATA_WIDTH'(sat_min(DATA_WIDTH));
        end else begin
            y = shifted[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/requant_output_router.sv
// Captures a batch of PE accumulators, requantizes and packs them into SPAD
// words, and streams the words out with auto-incrementing addresses. A shadow
// buffer holds the next batch while the current one drains so batches chain
// without a bubble.
module requant_output_router
    import output_router_pkg::*;
#(
    parameter int SPAD_ADDR_WIDTH = 8,
    parameter int SPAD_DATA_WIDTH = 16,
    parameter int ROUTER_COUNT    = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int ACC_WIDTH       = 16,
    parameter int SHIFT_WIDTH     = 4
) (
    input  logic                                     i_clk,
    input  logic                                     i_nrst,
    input  logic                                     i_en,
    input  logic [ROUTER_COUNT-1:0][ACC_WIDTH-1:0]   i_ifmap,
    input  logic [ROUTER_COUNT-1:0]                  i_valid,
    input  logic [SHIFT_WIDTH-1:0]                   i_shift,
    input  logic                                     i_relu_en,
    input  logic [SPAD_ADDR_WIDTH-1:0]               i_base_addr,
    input  logic                                     i_addr_load,
    output logic                                     o_ready,
    output logic [SPAD_DATA_WIDTH-1:0]               o_data_out,
    output logic [SPAD_ADDR_WIDTH-1:0]               o_addr,
    output logic                                     o_valid,
    input  logic                                     i_ready,
    output logic                                     o_done
);

    localparam int MEMBER_CNT = calc_member_cnt(SPAD_DATA_WIDTH, DATA_WIDTH);
    localparam int GROUP_CNT  = calc_group_cnt(ROUTER_COUNT, MEMBER_CNT);
    localparam int LANE_PAD   = GROUP_CNT * MEMBER_CNT;
    localparam int PACK_W     = MEMBER_CNT * DATA_WIDTH;
    localparam int CNT_W      = (GROUP_CNT > 1) ? $clog2(GROUP_CNT) : 1;

    typedef logic [GROUP_CNT-1:0][SPAD_DATA_WIDTH-1:0] batch_t;

    logic [LANE_PAD-1:0][DATA_WIDTH-1:0] lane_q;
    batch_t                              cap_words;

    state_t                     state_reg, state_next;
    logic [CNT_W-1:0]           cnt_reg, cnt_next;
    logic                       shd_full_reg, shd_full_next;
    logic [SPAD_ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic                       done_reg;
    batch_t                     act_buf_reg;
    batch_t                     shd_buf_reg;

    logic capture;
    logic hs;
    logic last_hs;
    logic load_act_cap;
    logic load_act_shd;
    logic load_shd;

    // Requantize every lane; padding lanes past ROUTER_COUNT read as zero.
    for (genvar gi = 0; gi < LANE_PAD; gi++) begin : g_lane
        if (gi < ROUTER_COUNT) begin : g_real
            requant_unit #(
                .ACC_WIDTH  (ACC_WIDTH),
                .DATA_WIDTH (DATA_WIDTH),
                .SHIFT_WIDTH(SHIFT_WIDTH)
            ) u_requant (
                .x       (i_ifmap[gi]),
                .valid   (i_valid[gi]),
                .relu_en (i_relu_en),
                .shift   (i_shift),
                .y       (lane_q[gi])
            );
        end else begin : g_pad
            assign lane_q[gi] = '0;
        end
    end

    // Pack lanes into words; the lowest lane of each group lands in the MSBs.
    for (genvar gi = 0; gi < GROUP_CNT; gi++) begin : g_word
        logic [PACK_W-1:0] packed_word;
        for (genvar gm = 0; gm < MEMBER_CNT; gm++) begin : g_member
            assign packed_word[(MEMBER_CNT-1-gm)*DATA_WIDTH +: DATA_WIDTH] =
                lane_q[gi*MEMBER_CNT + gm];
        end
        assign cap_words[gi] = packed_word[SPAD_DATA_WIDTH-1:0];
    end

    assign o_ready    = !shd_full_reg;
    assign capture    = i_en && o_ready;
    assign o_valid    = (state_reg == OUT);
    assign hs         = o_valid && i_ready;
    assign last_hs    = hs && (cnt_reg == CNT_W'(GROUP_CNT - 1));
    assign o_data_out = o_valid ? act_buf_reg[cnt_reg] : '0;
    assign o_addr     = addr_reg;
    assign o_done     = done_reg;

    // Next-state logic: word counter, buffer routing and address generation.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        shd_full_next = shd_full_reg;
        load_act_cap  = 1'b0;
        load_act_shd  = 1'b0;
        load_shd      = 1'b0;
        addr_next     = addr_reg;

        case (state_reg)
            IDLE: begin
                if (capture) begin
                    state_next   = OUT;
                    cnt_next     = '0;
                    load_act_cap = 1'b1;
                end
            end
            OUT: begin
                if (last_hs) begin
                    cnt_next = '0;
                    if (shd_full_reg) begin
                        load_act_shd  = 1'b1;
                        shd_full_next = 1'b0;
                    end else if (capture) begin
                        // Active buffer frees this cycle, so the new batch goes straight in.
                        load_act_cap = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    if (hs) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                    if (capture) begin
                        load_shd      = 1'b1;
                        shd_full_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A base load must not disturb a batch that is about to start.
        if (hs) begin
            addr_next = addr_reg + SPAD_ADDR_WIDTH'(1);
        end else if (i_addr_load && (state_reg == IDLE) && !shd_full_reg && !capture) begin
            addr_next = i_base_addr;
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            shd_full_reg <= 1'b0;
            addr_reg     <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            shd_full_reg <= shd_full_next;
            addr_reg     <= addr_next;
            done_reg     <= last_hs;
        end
    end

    // Batch storage; contents are only meaningful while the matching flag/state says so.
    always_ff @(posedge i_clk) begin
        if (load_act_cap) begin
            act_buf_reg <= cap_words;
        end else if (load_act_shd) begin
            act_buf_reg <= shd_buf_reg;
        end
        if (load_shd) begin
            shd_buf_reg <= cap_words;
        end
    end

endmodule

// File: tb/tb_requant_output_router.sv
// Directed bench for requant_output_router: table of single-batch vectors
// plus hand-written backpressure, back-to-back, wrap and reset sequences.
module tb_requant_output_router;

    logic                  i_clk;
    logic                  i_nrst;
    logic                  i_en;
    logic [3:0][15:0]      i_ifmap;
    logic [3:0]            i_valid;
    logic [3:0]            i_shift;
    logic                  i_relu_en;
    logic [7:0]            i_base_addr;
    logic                  i_addr_load;
    logic                  o_ready;
    logic [15:0]           o_data_out;
    logic [7:0]            o_addr;
    logic                  o_valid;
    logic                  i_ready;
    logic                  o_done;

    requant_output_router dut (
        .i_clk       (i_clk),
        .i_nrst      (i_nrst),
        .i_en        (i_en),
        .i_ifmap     (i_ifmap),
        .i_valid     (i_valid),
        .i_shift     (i_shift),
        .i_relu_en   (i_relu_en),
        .i_base_addr (i_base_addr),
        .i_addr_load (i_addr_load),
        .o_ready     (o_ready),
        .o_data_out  (o_data_out),
        .o_addr      (o_addr),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_done      (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0][15:0] lane;
        logic [3:0]       valid;
        logic [3:0]       shift;
        logic             relu;
        logic [15:0]      w0;
        logic [15:0]      w1;
    } vec_t;

    localparam int NVEC = 6;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic set_vec(input int idx, input logic [15:0] l0, input logic [15:0] l1,
                           input logic [15:0] l2, input logic [15:0] l3,
                           input logic [3:0] valid, input logic [3:0] shift, input logic relu,
                           input logic [15:0] w0, input logic [15:0] w1);
        vecs[idx].lane[0] = l0;
        vecs[idx].lane[1] = l1;
        vecs[idx].lane[2] = l2;
        vecs[idx].lane[3] = l3;
        vecs[idx].valid   = valid;
        vecs[idx].shift   = shift;
        vecs[idx].relu    = relu;
        vecs[idx].w0      = w0;
        vecs[idx].w1      = w1;
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic load_base(input logic [7:0] a);
        i_base_addr = a;
        i_addr_load = 1'b1;
        step();
        i_addr_load = 1'b0;
    endtask

    task automatic drive(input int idx);
        i_ifmap   = vecs[idx].lane;
        i_valid   = vecs[idx].valid;
        i_shift   = vecs[idx].shift;
        i_relu_en = vecs[idx].relu;
    endtask

    // Present a batch for exactly one edge.
    task automatic offer(input int idx);
        drive(idx);
        i_en = 1'b1;
        step();
        i_en = 1'b0;
    endtask

    initial begin
        set_vec(0, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 4'hF, 4'd0, 1'b0, 16'h0102, 16'h0304);
        set_vec(1, 16'h0018, 16'h7FFF, 16'hFF00, 16'h8000, 4'hF, 4'd4, 1'b0, 16'h027F, 16'hF080);
        set_vec(2, 16'h0018, 16'h7FFF, 16'hFF00, 16'h8000, 4'hF, 4'd4, 1'b1, 16'h027F, 16'h0000);
        set_vec(3, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 4'b1010, 4'd0, 1'b0, 16'h0002, 16'h0004);
        // shift=1 rounding: 3->2, -3->-1, 5->3, -1->0
        set_vec(4, 16'h0003, 16'hFFFD, 16'h0005, 16'hFFFF, 4'hF, 4'd1, 1'b0, 16'h02FF, 16'h0300);
        // saturation edges: -128 ok, -129 clamps, 128 clamps, 127 ok
        set_vec(5, 16'hFF80, 16'hFF7F, 16'h0080, 16'h007F, 4'hF, 4'd0, 1'b0, 16'h8080, 16'h7F7F);

        i_nrst = 1'b0;
        i_en = 1'b0;
        i_ifmap = '0;
        i_valid = '0;
        i_shift = '0;
        i_relu_en = 1'b0;
        i_base_addr = '0;
        i_addr_load = 1'b0;
        i_ready = 1'b1;

        step();
        check("reset_ready", {31'd0, o_ready}, 32'd1);
        check("reset_valid", {31'd0, o_valid}, 32'd0);
        check("reset_data", {16'd0, o_data_out}, 32'd0);
        check("reset_addr", {24'd0, o_addr}, 32'd0);
        check("reset_done", {31'd0, o_done}, 32'd0);
        @(negedge i_clk);
        i_nrst = 1'b1;
        step();

        // Single-batch vectors, full-rate downstream.
        for (int k = 0; k < NVEC; k++) begin
            i_ready = 1'b1;
            load_base(8'h10);
            offer(k);
            check($sformatf("v%0d_w0_valid", k), {31'd0, o_valid}, 32'd1);
            check($sformatf("v%0d_w0_data", k), {16'd0, o_data_out}, {16'd0, vecs[k].w0});
            check($sformatf("v%0d_w0_addr", k), {24'd0, o_addr}, 32'h10);
            check($sformatf("v%0d_w0_done", k), {31'd0, o_done}, 32'd0);
            step();
            check($sformatf("v%0d_w1_data", k), {16'd0, o_data_out}, {16'd0, vecs[k].w1});
            check($sformatf("v%0d_w1_addr", k), {24'd0, o_addr}, 32'h11);
            step();
            check($sformatf("v%0d_done", k), {31'd0, o_done}, 32'd1);
            check($sformatf("v%0d_idle_valid", k), {31'd0, o_valid}, 32'd0);
            check($sformatf("v%0d_idle_data", k), {16'd0, o_data_out}, 32'd0);
            $display("vector %0d: expected words 0x%04h 0x%04h", k, vecs[k].w0, vecs[k].w1);
        end

        // Backpressure: hold word 0 for three cycles.
        load_base(8'h20);
        i_ready = 1'b0;
        offer(0);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp%0d_valid", c), {31'd0, o_valid}, 32'd1);
            check($sformatf("bp%0d_data", c), {16'd0, o_data_out}, 32'h0102);
            check($sformatf("bp%0d_addr", c), {24'd0, o_addr}, 32'h20);
            check($sformatf("bp%0d_done", c), {31'd0, o_done}, 32'd0);
            if (c < 2) step();
        end
        i_ready = 1'b1;
        step();
        check("bp_w1_data", {16'd0, o_data_out}, 32'h0304);
        check("bp_w1_addr", {24'd0, o_addr}, 32'h21);
        step();
        check("bp_done", {31'd0, o_done}, 32'd1);
        step();
        check("bp_done_once", {31'd0, o_done}, 32'd0);
        $display("backpressure batch: 0x0102@0x20 held 3 cycles, 0x0304@0x21");

        // Back-to-back: second batch offered during first batch's word 0.
        load_base(8'h10);
        offer(0);
        check("b2b_a0_data", {16'd0, o_data_out}, 32'h0102);
        check("b2b_a0_addr", {24'd0, o_addr}, 32'h10);
        offer(1);
        check("b2b_a1_data", {16'd0, o_data_out}, 32'h0304);
        check("b2b_a1_addr", {24'd0, o_addr}, 32'h11);
        check("b2b_not_ready", {31'd0, o_ready}, 32'd0);
        offer(3);   // o_ready is low, so this batch must be dropped
        check("b2b_b0_valid", {31'd0, o_valid}, 32'd1);
        check("b2b_b0_data", {16'd0, o_data_out}, 32'h027F);
        check("b2b_b0_addr", {24'd0, o_addr}, 32'h12);
        check("b2b_a_done", {31'd0, o_done}, 32'd1);
        step();
        check("b2b_b1_data", {16'd0, o_data_out}, 32'hF080);
        check("b2b_b1_addr", {24'd0, o_addr}, 32'h13);
        check("b2b_b1_done", {31'd0, o_done}, 32'd0);
        step();
        check("b2b_b_done", {31'd0, o_done}, 32'd1);
        check("b2b_end_valid", {31'd0, o_valid}, 32'd0);
        step();
        check("b2b_third_ignored", {31'd0, o_valid}, 32'd0);
        check("b2b_no_extra_done", {31'd0, o_done}, 32'd0);
        check("b2b_ready_again", {31'd0, o_ready}, 32'd1);
        $display("back-to-back: 0x0102@0x10 0x0304@0x11 0x027F@0x12 0xF080@0x13");

        // Address wrap at the top of the address space.
        load_base(8'hFF);
        offer(0);
        check("wrap_w0_addr", {24'd0, o_addr}, 32'hFF);
        check("wrap_w0_data", {16'd0, o_data_out}, 32'h0102);
        step();
        check("wrap_w1_addr", {24'd0, o_addr}, 32'h00);
        check("wrap_w1_data", {16'd0, o_data_out}, 32'h0304);
        step();
        check("wrap_done", {31'd0, o_done}, 32'd1);
        $display("wrap batch: 0x0102@0xFF 0x0304@0x00");

        // Asynchronous reset in the middle of a stalled batch.
        i_ready = 1'b0;
        offer(1);
        check("rst_pre_valid", {31'd0, o_valid}, 32'd1);
        #3;
        i_nrst = 1'b0;
        #1;
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_addr", {24'd0, o_addr}, 32'd0);
        check("rst_data", {16'd0, o_data_out}, 32'd0);
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        @(negedge i_clk);
        i_nrst = 1'b1;
        i_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("rst_after%0d_done", c), {31'd0, o_done}, 32'd0);
            check($sformatf("rst_after%0d_valid", c), {31'd0, o_valid}, 32'd0);
        end
        $display("mid-batch reset: batch discarded");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
